// File: rtl/regfile_sequencer_if.sv
// Control/handshake bundle between the instruction decoder, the ALU and
// the register-file sequencer.
interface regfile_sequencer_if #(
  parameter int DATA_W = 8
);
  // instr_valid/instr_ready: an instruction transfers on a rising clk edge
  // where both are high; valid may be raised at any time, and ready never
  // depends combinationally on valid.
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [2:0]        instr_rd;
  logic [2:0]        instr_rs;
  logic [DATA_W-1:0] imm_in;
  logic              alu_start;
  logic              alu_done;
  logic [1:0]        enab;
  logic [2:0]        mux_sel;
  logic [2:0]        reg_sel;
  logic [2:0]        seg;
  logic [DATA_W-1:0] or2_out;
  logic              done;
  logic              err;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, imm_in, alu_done,
    input  instr_ready, alu_start, enab, mux_sel, reg_sel, seg, or2_out,
           done, err
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, imm_in, alu_done,
    output instr_ready, alu_start, enab, mux_sel, reg_sel, seg, or2_out,
           done, err
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Sequences decoded register-transfer instructions onto the 8x8 register
// file control bus, including the multi-cycle ALU read/wait/write-back flow.
module regfile_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sequencer_if.slave  bus,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WRITE, S_READ, S_ALU_WAIT, S_WB
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(ALU_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        rd_q, rd_d;
  logic [1:0]        enab_q, enab_d;
  logic [2:0]        mux_q, mux_d;
  logic [2:0]        reg_sel_q, reg_sel_d;
  logic [2:0]        seg_q, seg_d;
  logic [DATA_W-1:0] or2_q, or2_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      enab_q    <= 2'b11;
      mux_q     <= 3'b000;
      reg_sel_q <= 3'b000;
      seg_q     <= 3'b000;
      or2_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      enab_q    <= enab_d;
      mux_q     <= mux_d;
      reg_sel_q <= reg_sel_d;
      seg_q     <= seg_d;
      or2_q     <= or2_d;
      start_q   <= start_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  // Outputs are computed for the state being entered and registered with it,
  // so every control value appears in the same cycle as its state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    enab_d    = 2'b11;
    mux_d     = mux_q;
    reg_sel_d = reg_sel_q;
    seg_d     = seg_q;
    or2_d     = or2_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && ready_q) begin
          rd_d = bus.instr_rd;
          case (bus.instr_op)
            3'b000: begin
              state_d = S_WRITE;
              done_d  = 1'b1;
            end
            3'b001: begin
              state_d   = S_WRITE;
              enab_d    = 2'b01;
              seg_d     = bus.instr_rd;
              mux_d     = 3'b001;
              reg_sel_d = bus.instr_rs;
              done_d    = 1'b1;
            end
            3'b010: begin
              state_d = S_WRITE;
              enab_d  = 2'b01;
              seg_d   = bus.instr_rd;
              mux_d   = 3'b010;
              or2_d   = bus.imm_in;
              done_d  = 1'b1;
            end
            3'b011: begin
              state_d = S_READ;
              enab_d  = 2'b10;
              seg_d   = bus.instr_rs;
            end
            3'b100: begin
              state_d = S_CLEAR;
              enab_d  = 2'b00;
              done_d  = 1'b1;
            end
            3'b101: begin
              state_d = S_WRITE;
              enab_d  = 2'b01;
              seg_d   = bus.instr_rd;
              mux_d   = 3'b000;
              done_d  = 1'b1;
            end
            default: begin
              state_d = S_WRITE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_READ: begin
        state_d = S_ALU_WAIT;
        start_d = 1'b1;
        cnt_d   = '0;
      end
      S_ALU_WAIT: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (bus.alu_done) begin
          state_d = S_WB;
          enab_d  = 2'b01;
          mux_d   = 3'b011;
          seg_d   = rd_q;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_WB;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_start   = start_q;
  assign bus.enab        = enab_q;
  assign bus.mux_sel     = mux_q;
  assign bus.reg_sel     = reg_sel_q;
  assign bus.seg         = seg_q;
  assign bus.or2_out     = or2_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized scoreboard bench for regfile_sequencer: each issued instruction
// pushes its expected, cycle-stamped control events; a monitor pops them.
module tb_regfile_sequencer;

  localparam int DATA_W      = 8;
  localparam int ALU_TIMEOUT = 16;
  localparam int EW          = 38;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_imm = 8'h00;
  logic [EW-1:0] exp_q[$];

  regfile_sequencer_if #(.DATA_W(DATA_W)) bus();

  regfile_sequencer #(.DATA_W(DATA_W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One control event: cycle stamp plus the fields that matter for it.
  function automatic logic [EW-1:0] ev(input int c, input logic [1:0] en,
      input logic [2:0] mx, input logic [2:0] rs, input logic [2:0] sg,
      input logic [7:0] d, input logic st, input logic dn, input logic er);
    return {16'(c), en, mx, rs, sg, d, st, dn, er};
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [EW-1:0] obs;
    logic [EW-1:0] expv;
    logic          wr;
    forever begin
      @(negedge clk);
      if (bus.enab != 2'b11 || bus.done || bus.err || bus.alu_start) begin
        wr  = (bus.enab == 2'b01);
        obs = ev(cyc, bus.enab,
                 wr ? bus.mux_sel : 3'b000,
                 (wr && bus.mux_sel == 3'b001) ? bus.reg_sel : 3'b000,
                 (wr || bus.enab == 2'b10) ? bus.seg : 3'b000,
                 (wr && bus.mux_sel == 3'b010) ? bus.or2_out : 8'h00,
                 bus.alu_start, bus.done, bus.err);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event got=%h want=none (cycle %0d)", obs, cyc);
        end else begin
          expv = exp_q.pop_front();
          check("event", 64'(obs), 64'(expv));
        end
      end
    end
  endtask

  // driver: entered and left on a falling edge; d = alu_done wait index
  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [7:0] imm,
                       input int d);
    int g;
    int a;
    int fin;
    g = 0;
    while (!bus.instr_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_issue", 64'(bus.instr_ready), 64'd1);
    if (!bus.instr_ready) return;
    a = cyc + 1;
    fin = a;
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs    = rs;
    bus.imm_in      = imm;
    bus.alu_done    = (op != 3'b011) ? 1'($urandom_range(0, 1)) : 1'b0;
    case (op)
      3'b000: exp_q.push_back(ev(a, 2'b11, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0));
      3'b001: exp_q.push_back(ev(a, 2'b01, 3'b001, rs, rd, 8'h00, 1'b0, 1'b1, 1'b0));
      3'b010: begin
        exp_q.push_back(ev(a, 2'b01, 3'b010, 3'b000, rd, imm, 1'b0, 1'b1, 1'b0));
        last_imm = imm;
      end
      3'b011: begin
        exp_q.push_back(ev(a, 2'b10, 3'b000, 3'b000, rs, 8'h00, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(a + 1, 2'b11, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0));
        if (d < ALU_TIMEOUT) begin
          fin = a + 2 + d;
          exp_q.push_back(ev(fin, 2'b01, 3'b011, 3'b000, rd, 8'h00, 1'b0, 1'b1, 1'b0));
        end else begin
          fin = a + 1 + ALU_TIMEOUT;
          exp_q.push_back(ev(fin, 2'b11, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1));
        end
      end
      3'b100: exp_q.push_back(ev(a, 2'b00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0));
      3'b101: exp_q.push_back(ev(a, 2'b01, 3'b000, 3'b000, rd, 8'h00, 1'b0, 1'b1, 1'b0));
      default: exp_q.push_back(ev(a, 2'b11, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1));
    endcase
    @(negedge clk);
    check("ready_low_after_accept", 64'(bus.instr_ready), 64'd0);
    // valid while busy must be dropped, not queued
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.instr_op    = 3'($urandom_range(0, 7));
    bus.imm_in      = 8'($urandom_range(0, 255));
    bus.alu_done    = 1'b0;
    while (cyc < fin + 1) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.alu_done = (op == 3'b011 && d < ALU_TIMEOUT && cyc == a + 1 + d);
    end
    bus.alu_done = 1'b0;
    check("ready_back", 64'(bus.instr_ready), 64'd1);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'b000;
    bus.instr_rd    = 3'b000;
    bus.instr_rs    = 3'b000;
    bus.imm_in      = 8'h00;
    bus.alu_done    = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enab", 64'(bus.enab), 64'd3);
    check("rst_ready", 64'(bus.instr_ready), 64'd1);
    check("rst_alu_start", 64'(bus.alu_start), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_or2", 64'(bus.or2_out), 64'd0);
    check("rst_mux_seg", 64'({bus.mux_sel, bus.reg_sel, bus.seg}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b010, 3'd3, 3'd0, 8'hA5, 0);
    issue(3'b001, 3'd5, 3'd3, 8'h00, 0);
    issue(3'b011, 3'd2, 3'd4, 8'h00, 3);
    issue(3'b011, 3'd6, 3'd1, 8'h00, 1000);
    issue(3'b011, 3'd7, 3'd0, 8'h00, ALU_TIMEOUT - 1);
    issue(3'b011, 3'd1, 3'd5, 8'h00, 0);
    issue(3'b111, 3'd0, 3'd0, 8'h00, 0);
    issue(3'b100, 3'd0, 3'd0, 8'h00, 0);
    issue(3'b110, 3'd4, 3'd4, 8'h00, 0);
    issue(3'b000, 3'd0, 3'd0, 8'h00, 0);
    issue(3'b101, 3'd6, 3'd2, 8'h00, 0);

    // reset while waiting on the ALU abandons the instruction
    begin
      int a;
      a = cyc + 1;
      bus.instr_valid = 1'b1;
      bus.instr_op    = 3'b011;
      bus.instr_rd    = 3'd1;
      bus.instr_rs    = 3'd2;
      exp_q.push_back(ev(a, 2'b10, 3'b000, 3'b000, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(a + 1, 2'b11, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      bus.instr_valid = 1'b0;
      while (cyc < a + 4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_enab", 64'(bus.enab), 64'd3);
      check("midrst_ready", 64'(bus.instr_ready), 64'd1);
      check("midrst_done_err", 64'({bus.done, bus.err, bus.alu_start}), 64'd0);
      check("midrst_or2", 64'(bus.or2_out), 64'd0);
      last_imm = 8'h00;
      bus.alu_done = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 20));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("or2_holds_last_mvi", 64'(bus.or2_out), 64'(last_imm));
    check("idle_enab", 64'(bus.enab), 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
